spi_slave: RTL and testbench
============================

// Module: spi_slave
// PURPOSE
//  SPI mode-0 responder (CPOL=0, CPHA=0, MSB first), the far end of our SPI master link.
//  Oversamples sclk/cs_n/mosi in the local clk domain, deserialises MOSI into words,
//  and serialises a host-supplied word onto MISO in the same frame.
//  Host side: valid/ready TX load and a 1-cycle rx_valid strobe.
// PARAMETERS
//  DATA_WIDTH   8  bits per SPI word
//  SYNC_STAGES  2  flops in each input synchroniser (>=2)
// PORTS
//  clk          in   1           system clock; every flop in the block is on this clock
//  reset_n      in   1           asynchronous, active-low reset
//  sclk         in   1           SPI clock from master (async)
//  cs_n         in   1           chip select from master, active low (async)
//  mosi         in   1           master-out data (async)
//  miso         out  1           slave-out data
//  miso_oe      out  1           MISO output enable, 1 while selected
//  tx_data      in   DATA_WIDTH  word to return to the master
//  tx_valid     in   1           tx_data valid
//  tx_ready     out  1           TX holding register empty
//  rx_data      out  DATA_WIDTH  last received word, held until the next word completes
//  rx_valid     out  1           1-cycle strobe, rx_data updated
//  tx_underrun  out  1           1-cycle strobe, word started with an empty TX buffer
//  frame_err    out  1           1-cycle strobe, cs_n deasserted mid-word
//  busy         out  1           1 while cs_n (synchronised) is low
// BEHAVIOUR
//  Reset values: miso=0, miso_oe=0, tx_ready=1, rx_data=0, rx_valid=0,
//   tx_underrun=0, frame_err=0, busy=0. State=IDLE; bit_cnt, shift registers and TX buffer cleared.
//  Input sync: sclk, cs_n and mosi each pass through SYNC_STAGES flops.
//   Edges are detected from the last two stages.
//   Supported sclk: period >= 8 clk cycles; faster is out of spec.
//  TX buffer: one entry. Accept on tx_valid && tx_ready, then tx_ready=0.
//   The buffer empties (tx_ready=1 on the next cycle) when a word is loaded into tx_shift.
//  States:
//   IDLE  -> LOAD on cs_n falling edge.
//   LOAD  (1 cycle): tx_shift <= buffer, or all-zeros plus a tx_underrun pulse if empty;
//         bit_cnt <= 0 -> SHIFT.
//   SHIFT: on sclk rising edge: rx_shift <= {rx_shift[W-2:0], mosi}; bit_cnt++.
//         On sclk falling edge: tx_shift <<= 1.
//         When bit_cnt reaches DATA_WIDTH on a rising edge: rx_data <= new word;
//         rx_valid=1 next cycle; bit_cnt <= 0.
//         The next TX word is loaded into tx_shift (underrun rule as in LOAD) and appears
//         on the following falling edge. Back-to-back words continue while cs_n stays low.
//   Any state: cs_n rising edge -> IDLE.
//         If bit_cnt != 0, pulse frame_err and discard the partial word (no rx_valid).
//  miso = tx_shift[W-1] while busy, else 0. miso_oe = busy.
//   MSB is valid within SYNC_STAGES+2 clk of cs_n falling.
//  Simultaneous events:
//   - tx accept in the same cycle as a buffer load: the load takes the old contents
//     (or underruns); the new word stays buffered.
//   - cs_n rising edge in the same cycle as the sclk edge that completes a word:
//     the word completes (rx_valid) first, then IDLE; no frame_err.
//  reset_n asserted mid-frame: all outputs return to reset values immediately.
//   A pending TX word is lost.
// TESTING
//  1 Reset: drive reset_n=0 mid-frame -> all outputs at reset values, tx_ready=1.
//  2 Single word: preload tx 8'hA5, master sends 8'h3C -> rx_data=8'h3C with one rx_valid;
//    master samples 8'hA5 on MISO; tx_ready returns to 1.
//  3 Back-to-back: preload 8'h81, then load 8'h7E while the first word shifts,
//    master sends 8'h01,8'hFF in one frame -> rx_valid twice (01, FF); MISO 81 then 7E.
//  4 Underrun: no tx load, master sends 8'h55 -> tx_underrun pulse once;
//    MISO all zeros; rx_data=8'h55.
//  5 Abort: raise cs_n after 5 bits -> frame_err pulse, no rx_valid, busy=0;
//    the next full frame receives correctly.
//  6 Edge coincidence: cs_n rises on the 8th-bit sample cycle -> rx_valid=1, frame_err=0.

Source files
------------

// File: rtl/spi_slave.sv
// SPI mode-0 responder: oversamples sclk/cs_n/mosi on clk, receives MOSI words and
// returns host-supplied words on MISO within the same chip-select frame.
module spi_slave #(
  parameter int DATA_WIDTH  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  sclk,
  input  logic                  cs_n,
  input  logic                  mosi,
  output logic                  miso,
  output logic                  miso_oe,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  tx_underrun,
  output logic                  frame_err,
  output logic                  busy
);

  localparam int CW = $clog2(DATA_WIDTH + 1);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;

  state_t                  state;
  logic [SYNC_STAGES-1:0]  sclk_sync;
  logic [SYNC_STAGES-1:0]  cs_sync;
  logic [SYNC_STAGES-1:0]  mosi_sync;
  logic [CW-1:0]           bit_cnt;
  logic [DATA_WIDTH-2:0]   rx_shift;
  logic [DATA_WIDTH-1:0]   rx_next;
  logic [DATA_WIDTH-1:0]   tx_shift;
  logic [DATA_WIDTH-1:0]   tx_buf;
  logic                    reload;
  logic                    under_pend;
  logic                    sclk_rise;
  logic                    sclk_fall;
  logic                    cs_rise;
  logic                    cs_fall;
  logic                    word_done;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sclk_sync <= '0;
      cs_sync   <= '1;
      mosi_sync <= '0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
    end
  end

  // mosi is taken from the older stage so it reflects the line just before the sclk rise
  assign sclk_rise = sclk_sync[SYNC_STAGES-2] & ~sclk_sync[SYNC_STAGES-1];
  assign sclk_fall = ~sclk_sync[SYNC_STAGES-2] & sclk_sync[SYNC_STAGES-1];
  assign cs_rise   = cs_sync[SYNC_STAGES-2] & ~cs_sync[SYNC_STAGES-1];
  assign cs_fall   = ~cs_sync[SYNC_STAGES-2] & cs_sync[SYNC_STAGES-1];
  assign rx_next   = {rx_shift, mosi_sync[SYNC_STAGES-1]};
  assign word_done = (state == SHIFT) && sclk_rise && (bit_cnt == CW'(DATA_WIDTH - 1));

  assign miso    = busy & tx_shift[DATA_WIDTH-1];
  assign miso_oe = busy;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      rx_shift    <= '0;
      tx_shift    <= '0;
      tx_buf      <= '0;
      tx_ready    <= 1'b1;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      tx_underrun <= 1'b0;
      frame_err   <= 1'b0;
      busy        <= 1'b0;
      reload      <= 1'b0;
      under_pend  <= 1'b0;
    end else begin
      rx_valid    <= 1'b0;
      tx_underrun <= 1'b0;
      frame_err   <= 1'b0;
      busy        <= ~cs_sync[SYNC_STAGES-2];

      case (state)
        IDLE: begin
          if (cs_fall) state <= LOAD;
        end
        LOAD: begin
          if (!tx_ready) begin
            tx_shift <= tx_buf;
            tx_ready <= 1'b1;
          end else begin
            tx_shift    <= '0;
            tx_underrun <= 1'b1;
          end
          bit_cnt    <= '0;
          reload     <= 1'b0;
          under_pend <= 1'b0;
          state      <= SHIFT;
        end
        SHIFT: begin
          if (sclk_rise) begin
            rx_shift <= rx_next[DATA_WIDTH-2:0];
            if (word_done) begin
              rx_data  <= rx_next;
              rx_valid <= 1'b1;
              bit_cnt  <= '0;
              reload   <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + CW'(1);
            end
            // An empty-buffer reload only counts as an underrun once the next word really starts
            if (bit_cnt == '0 && under_pend) begin
              tx_underrun <= 1'b1;
              under_pend  <= 1'b0;
            end
          end
          if (sclk_fall) begin
            if (reload) begin
              reload <= 1'b0;
              if (!tx_ready) begin
                tx_shift <= tx_buf;
                tx_ready <= 1'b1;
              end else begin
                tx_shift   <= '0;
                under_pend <= 1'b1;
              end
            end else begin
              tx_shift <= tx_shift << 1;
            end
          end
        end
        default: state <= IDLE;
      endcase

      if (cs_rise) begin
        state      <= IDLE;
        reload     <= 1'b0;
        under_pend <= 1'b0;
        tx_shift   <= '0;
        if (bit_cnt != '0 && !word_done) begin
          frame_err <= 1'b1;
          bit_cnt   <= '0;
        end
      end

      // Accept comes last so a same-cycle underrun load still leaves the new word buffered
      if (tx_valid && tx_ready) begin
        tx_buf   <= tx_data;
        tx_ready <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: an SPI master model drives frames, a scoreboard
// queue holds expected rx words and a monitor checks each rx_valid strobe.
module tb_spi_slave;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         sclk = 1'b0;
  logic         cs_n = 1'b1;
  logic         mosi = 1'b0;
  logic         miso;
  logic         miso_oe;
  logic [W-1:0] tx_data = '0;
  logic         tx_valid = 1'b0;
  logic         tx_ready;
  logic [W-1:0] rx_data;
  logic         rx_valid;
  logic         tx_underrun;
  logic         frame_err;
  logic         busy;

  int checks = 0;
  int errors = 0;
  int rx_cnt = 0;
  int under_cnt = 0;
  int ferr_cnt = 0;
  logic [W-1:0] exp_rx[$];
  logic [W-1:0] mon_exp;

  spi_slave #(.DATA_WIDTH(W), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset_n(reset_n), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
    .miso(miso), .miso_oe(miso_oe), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_underrun(tx_underrun), .frame_err(frame_err), .busy(busy)
  );

  always #5 clk = ~clk;

  // Scoreboard monitor: every rx_valid strobe must match the oldest queued word
  always @(negedge clk) begin
    if (reset_n) begin
      if (rx_valid) begin
        checks++;
        rx_cnt++;
        if (exp_rx.size() == 0) begin
          errors++;
          $display("[TB] FAIL rx_unexpected actual %h required none", rx_data);
        end else begin
          mon_exp = exp_rx.pop_front();
          if (rx_data !== mon_exp) begin
            errors++;
            $display("[TB] FAIL rx_data actual %h required %h", rx_data, mon_exp);
          end
        end
      end
      if (tx_underrun) under_cnt++;
      if (frame_err) ferr_cnt++;
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog");
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load_tx(input logic [W-1:0] d);
    int t = 0;
    while (!tx_ready && t < 200) begin
      wait_clk(1);
      t++;
    end
    check_output("tx_ready_wait", {31'd0, tx_ready}, 32'd1);
    tx_data  = d;
    tx_valid = 1'b1;
    wait_clk(1);
    tx_valid = 1'b0;
  endtask

  task automatic spi_begin();
    cs_n = 1'b0;
    wait_clk(6);
  endtask

  task automatic spi_bits(input logic [W-1:0] d, input int n, output logic [W-1:0] got);
    got = '0;
    for (int i = 0; i < n; i++) begin
      mosi = d[W-1-i];
      wait_clk(5);
      sclk = 1'b1;
      got = {got[W-2:0], miso};
      wait_clk(5);
      sclk = 1'b0;
    end
  endtask

  task automatic spi_end();
    wait_clk(4);
    cs_n = 1'b1;
    wait_clk(8);
  endtask

  task automatic apply_stimulus(input logic [W-1:0] d, output logic [W-1:0] got);
    exp_rx.push_back(d);
    spi_begin();
    spi_bits(d, W, got);
    spi_end();
  endtask

  logic [W-1:0] got0, got1;
  int u0, r0, f0;

  initial begin
    // Power-on reset state
    wait_clk(3);
    check_output("rst_tx_ready", {31'd0, tx_ready}, 32'd1);
    check_output("rst_busy", {31'd0, busy}, 32'd0);
    check_output("rst_miso_oe", {31'd0, miso_oe}, 32'd0);
    check_output("rst_rx_data", {24'd0, rx_data}, 32'd0);
    reset_n = 1'b1;
    wait_clk(3);

    // Single word with preloaded TX
    u0 = under_cnt; r0 = rx_cnt; f0 = ferr_cnt;
    load_tx(8'hA5);
    check_output("single_tx_ready_low", {31'd0, tx_ready}, 32'd0);
    exp_rx.push_back(8'h3C);
    spi_begin();
    check_output("single_busy", {31'd0, busy}, 32'd1);
    check_output("single_miso_oe", {31'd0, miso_oe}, 32'd1);
    check_output("single_miso_msb", {31'd0, miso}, 32'd1);
    spi_bits(8'h3C, W, got0);
    spi_end();
    check_output("single_miso_word", {24'd0, got0}, 32'hA5);
    check_output("single_tx_ready_back", {31'd0, tx_ready}, 32'd1);
    check_output("single_rx_count", rx_cnt - r0, 32'd1);
    check_output("single_underruns", under_cnt - u0, 32'd0);
    check_output("single_busy_after", {31'd0, busy}, 32'd0);

    // Back-to-back words with a mid-word TX reload
    u0 = under_cnt; r0 = rx_cnt;
    load_tx(8'h81);
    exp_rx.push_back(8'h01);
    exp_rx.push_back(8'hFF);
    spi_begin();
    fork
      spi_bits(8'h01, W, got0);
      begin
        wait_clk(20);
        load_tx(8'h7E);
      end
    join
    spi_bits(8'hFF, W, got1);
    spi_end();
    check_output("b2b_miso_word0", {24'd0, got0}, 32'h81);
    check_output("b2b_miso_word1", {24'd0, got1}, 32'h7E);
    check_output("b2b_rx_count", rx_cnt - r0, 32'd2);
    check_output("b2b_underruns", under_cnt - u0, 32'd0);

    // Underrun: nothing loaded
    u0 = under_cnt; r0 = rx_cnt;
    apply_stimulus(8'h55, got0);
    check_output("under_miso_word", {24'd0, got0}, 32'h00);
    check_output("under_pulses", under_cnt - u0, 32'd1);
    check_output("under_rx_data", {24'd0, rx_data}, 32'h55);
    check_output("under_rx_count", rx_cnt - r0, 32'd1);

    // Abort after 5 bits, then a clean frame
    r0 = rx_cnt; f0 = ferr_cnt;
    spi_begin();
    spi_bits(8'hB4, 5, got0);
    spi_end();
    check_output("abort_frame_err", ferr_cnt - f0, 32'd1);
    check_output("abort_rx_count", rx_cnt - r0, 32'd0);
    check_output("abort_busy", {31'd0, busy}, 32'd0);
    check_output("abort_rx_held", {24'd0, rx_data}, 32'h55);
    f0 = ferr_cnt;
    load_tx(8'h96);
    apply_stimulus(8'hC3, got0);
    check_output("recover_miso_word", {24'd0, got0}, 32'h96);
    check_output("recover_rx_data", {24'd0, rx_data}, 32'hC3);
    check_output("recover_frame_err", ferr_cnt - f0, 32'd0);

    // cs_n rises together with the 8th sampling edge
    r0 = rx_cnt; f0 = ferr_cnt;
    exp_rx.push_back(8'hE7);
    spi_begin();
    spi_bits(8'hE7, 7, got0);
    mosi = 1'b1;
    wait_clk(5);
    sclk = 1'b1;
    cs_n = 1'b1;
    wait_clk(6);
    sclk = 1'b0;
    wait_clk(6);
    check_output("coinc_rx_count", rx_cnt - r0, 32'd1);
    check_output("coinc_frame_err", ferr_cnt - f0, 32'd0);
    check_output("coinc_rx_data", {24'd0, rx_data}, 32'hE7);
    check_output("coinc_busy", {31'd0, busy}, 32'd0);

    // Reset asserted mid-frame with a word pending in the TX buffer
    load_tx(8'h3F);
    spi_begin();
    spi_bits(8'hAA, 3, got0);
    load_tx(8'h12);
    check_output("midrst_pending", {31'd0, tx_ready}, 32'd0);
    check_output("midrst_busy_before", {31'd0, busy}, 32'd1);
    reset_n = 1'b0;
    #1;
    check_output("midrst_miso", {31'd0, miso}, 32'd0);
    check_output("midrst_miso_oe", {31'd0, miso_oe}, 32'd0);
    check_output("midrst_tx_ready", {31'd0, tx_ready}, 32'd1);
    check_output("midrst_rx_data", {24'd0, rx_data}, 32'd0);
    check_output("midrst_rx_valid", {31'd0, rx_valid}, 32'd0);
    check_output("midrst_underrun", {31'd0, tx_underrun}, 32'd0);
    check_output("midrst_frame_err", {31'd0, frame_err}, 32'd0);
    check_output("midrst_busy", {31'd0, busy}, 32'd0);
    cs_n = 1'b1;
    sclk = 1'b0;
    wait_clk(4);
    reset_n = 1'b1;
    wait_clk(6);
    check_output("postrst_tx_ready", {31'd0, tx_ready}, 32'd1);
    check_output("postrst_busy", {31'd0, busy}, 32'd0);

    check_output("scoreboard_drained", exp_rx.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
